// File: rtl/disc_pkg.sv
// Shared definitions for the discriminator channel array: FSM encoding,
// default parameter values and the counter saturation helper.
package disc_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HOLD = 2'd1,
    HIGH = 2'd2
  } disc_state_t;

  localparam int DEF_NCHAN    = 8;
  localparam int DEF_DEGLITCH = 3;
  localparam int DEF_STRETCH  = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_SEL_W    = 3;

  // All-ones value of a w-bit counter, returned in a 64-bit container.
  function automatic logic [63:0] cnt_sat(input int w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/disc_chan.sv
// One discriminator channel: 2-flop synchroniser, deglitch/stretch FSM, EDGE
// pulse and, when DISC_EDGE_CNT_EN is defined, a saturating rising-edge counter.
module disc_chan
  import disc_pkg::*;
#(
  parameter int DEGLITCH = DEF_DEGLITCH,
  parameter int STRETCH  = DEF_STRETCH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw,
  input  logic             invert,
  input  logic             mask,
  input  logic             cnt_clr,
  output logic             out,
  output logic             rise,
  output logic [CNT_W-1:0] cnt
);

  localparam int QW = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
  localparam int HW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [QW-1:0] QLAST = QW'(DEGLITCH - 1);
  localparam logic [HW-1:0] HLOAD = HW'(STRETCH - 1);

  logic          s1, s2, q;
  disc_state_t   state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          out_r, rise_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign q = (s2 ^ invert) & ~mask;

  // Mask overrides every state, including an in-progress stretch.
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    hcnt_nxt  = hcnt;
    if (mask) begin
      state_nxt = LOW;
      qcnt_nxt  = '0;
      hcnt_nxt  = '0;
    end else begin
      case (state)
        LOW: begin
          if (q) begin
            if (qcnt == QLAST) begin
              state_nxt = HOLD;
              hcnt_nxt  = HLOAD;
              qcnt_nxt  = '0;
            end else begin
              qcnt_nxt = qcnt + QW'(1);
            end
          end else begin
            qcnt_nxt = '0;
          end
        end
        HOLD: begin
          if (hcnt == '0) state_nxt = HIGH;
          else            hcnt_nxt  = hcnt - HW'(1);
        end
        HIGH: begin
          if (!q) begin
            if (qcnt == QLAST) begin
              state_nxt = LOW;
              qcnt_nxt  = '0;
            end else begin
              qcnt_nxt = qcnt + QW'(1);
            end
          end else begin
            qcnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = LOW;
          qcnt_nxt  = '0;
          hcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOW;
      qcnt   <= '0;
      hcnt   <= '0;
      out_r  <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      qcnt   <= qcnt_nxt;
      hcnt   <= hcnt_nxt;
      out_r  <= (state_nxt != LOW);
      rise_r <= (state == LOW) && (state_nxt == HOLD);
    end
  end

  assign out  = out_r;
  assign rise = rise_r;

`ifdef DISC_EDGE_CNT_EN
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_sat(CNT_W));

  logic [CNT_W-1:0] cnt_r;

  // Counts the registered EDGE pulse; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if (rise_r && (cnt_r != CMAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign cnt = cnt_r;
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign cnt        = '0;
`endif

endmodule

// File: rtl/disc_chan_array.sv
// NCHAN independent discriminator channels plus counter readback mux.
// Optional counters are enabled by defining DISC_EDGE_CNT_EN.
module disc_chan_array
  import disc_pkg::*;
#(
  parameter int NCHAN    = DEF_NCHAN,
  parameter int DEGLITCH = DEF_DEGLITCH,
  parameter int STRETCH  = DEF_STRETCH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SEL_W    = DEF_SEL_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCHAN-1:0] IN,
  input  logic [NCHAN-1:0] INVERT,
  input  logic [NCHAN-1:0] MASK,
  output logic [NCHAN-1:0] OUT,
  output logic [NCHAN-1:0] EDGE,
  input  logic             CNT_CLR,
  input  logic [SEL_W-1:0] CNT_SEL,
  output logic [CNT_W-1:0] CNT_VAL
);

  logic [NCHAN-1:0][CNT_W-1:0] cnt;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    disc_chan #(
      .DEGLITCH(DEGLITCH),
      .STRETCH (STRETCH),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk    (CLK),
      .rst    (RST),
      .raw    (IN[g]),
      .invert (INVERT[g]),
      .mask   (MASK[g]),
      .cnt_clr(CNT_CLR),
      .out    (OUT[g]),
      .rise   (EDGE[g]),
      .cnt    (cnt[g])
    );
  end

`ifdef DISC_EDGE_CNT_EN
  logic [CNT_W-1:0] sel_val;

  // Selects beyond the populated channels read back as zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (CNT_SEL == SEL_W'(i)) sel_val = cnt[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) CNT_VAL <= '0;
    else     CNT_VAL <= sel_val;
  end
`else
  logic unused_rb;
  assign unused_rb = ^{CNT_SEL, cnt};
  assign CNT_VAL   = '0;
`endif

endmodule
